regfile_writeback_queue: RTL and testbench

//   Write-side initiator for the 32x32 register file; the register file is the responder.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/wbq_fifo.sv | 81 ++++++++
 rtl/regfile_writeback_queue.sv | 114 +++++++++++
 tb/tb_regfile_writeback_queue.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write-back path.
package regfile_pkg;

   localparam int unsigned REG_AW = 5;
   localparam int unsigned REG_DW = 32;
   localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

   // One pending register write; "reg" is a keyword, so the address field is regIdx.
   typedef struct packed {
      logic [REG_AW-1:0] regIdx;
      logic [REG_DW-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/wbq_fifo.sv
// In-order circular buffer of pending write-backs. Exposes every slot plus a
// newest-first age index so the owner can run a forwarding search.
module wbq_fifo
   import regfile_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   localparam int unsigned PW = $clog2(DEPTH),
   localparam int unsigned CW = $clog2(DEPTH + 1)
) (
   input  logic          clock,
   input  logic          ctrl_reset_n,
   input  logic          push,
   input  wb_entry_t     pushEntry,
   input  logic          pop,
   input  logic          flush,
   output wb_entry_t     head,
   output wb_entry_t     entries [DEPTH],
   output logic [PW-1:0] ageIdx [DEPTH],
   output logic [CW-1:0] count
);

   wb_entry_t     mem [DEPTH];
   logic [PW-1:0] wrPtr_q, wrPtr_d;
   logic [PW-1:0] rdPtr_q, rdPtr_d;
   logic [CW-1:0] count_q, count_d;
   logic          doPush, doPop;

   // Flush beats both push and pop.
   assign doPush = push & ~flush;
   assign doPop  = pop & ~flush;

   // Next-state for pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      count_d = count_q;
      if (flush) begin
         wrPtr_d = '0;
         rdPtr_d = '0;
         count_d = '0;
      end else begin
         if (doPush) wrPtr_d = wrPtr_q + 1'b1;
         if (doPop)  rdPtr_d = rdPtr_q + 1'b1;
         unique case ({doPush, doPop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer and occupancy state.
   always_ff @(posedge clock or negedge ctrl_reset_n) begin
      if (!ctrl_reset_n) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         count_q <= count_d;
      end
   end

   // Storage needs no reset: slots are only meaningful below count.
   always_ff @(posedge clock) begin
      if (doPush) mem[wrPtr_q] <= pushEntry;
   end

   // Age index k names the k-th newest slot.
   always_comb begin
      for (int k = 0; k < int'(DEPTH); k++) begin
         entries[k] = mem[k];
         ageIdx[k]  = wrPtr_q - PW'(k + 1);
      end
   end

   assign head  = mem[rdPtr_q];
   assign count = count_q;

endmodule

// File: rtl/regfile_writeback_queue.sv
// Write-side initiator for the register file: filters and queues result writes,
// drains one per cycle into registered write-port outputs, and forwards in-flight data.
module regfile_writeback_queue
   import regfile_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = REG_AW,
   parameter int unsigned DW    = REG_DW,
   localparam int unsigned PW   = $clog2(DEPTH),
   localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
   input  logic          clock,
   input  logic          ctrl_reset_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [AW-1:0] in_reg,
   input  logic [DW-1:0] in_data,
   input  logic          wb_hold,
   input  logic          flush,
   output logic          ctrl_writeEnable,
   output logic [AW-1:0] ctrl_writeReg,
   output logic [DW-1:0] data_writeReg,
   input  logic [AW-1:0] fwd_regA,
   input  logic [AW-1:0] fwd_regB,
   output logic          fwd_hitA,
   output logic          fwd_hitB,
   output logic [DW-1:0] fwd_dataA,
   output logic [DW-1:0] fwd_dataB,
   output logic [CW-1:0] count
);

   wb_entry_t     pushEntry;
   wb_entry_t     head;
   wb_entry_t     entries [DEPTH];
   logic [PW-1:0] ageIdx [DEPTH];
   logic [CW-1:0] fifoCount;
   logic          push, pop;
   logic          we_q;
   logic [AW-1:0] wReg_q;
   logic [DW-1:0] wData_q;

   // Writes to r0 are accepted but never enqueued.
   assign in_ready         = fifoCount < CW'(DEPTH);
   assign push             = in_valid & in_ready & (in_reg != REG_ZERO);
   assign pop              = (fifoCount != '0) & ~wb_hold;
   assign pushEntry.regIdx = in_reg;
   assign pushEntry.data   = in_data;

   wbq_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clock       (clock),
      .ctrl_reset_n(ctrl_reset_n),
      .push        (push),
      .pushEntry   (pushEntry),
      .pop         (pop),
      .flush       (flush),
      .head        (head),
      .entries     (entries),
      .ageIdx      (ageIdx),
      .count       (fifoCount)
   );

   // Write-port register: strobe for one cycle per pop; address/data hold otherwise.
   always_ff @(posedge clock or negedge ctrl_reset_n) begin
      if (!ctrl_reset_n) begin
         we_q    <= 1'b0;
         wReg_q  <= '0;
         wData_q <= '0;
      end else if (flush) begin
         we_q <= 1'b0;
      end else if (pop) begin
         we_q    <= 1'b1;
         wReg_q  <= head.regIdx;
         wData_q <= head.data;
      end else begin
         we_q <= 1'b0;
      end
   end

   // Forwarding: output register is lowest priority, then queue oldest to newest so newest wins.
   always_comb begin
      fwd_hitA  = 1'b0;
      fwd_hitB  = 1'b0;
      fwd_dataA = '0;
      fwd_dataB = '0;
      if (we_q && wReg_q == fwd_regA && fwd_regA != REG_ZERO) begin
         fwd_hitA  = 1'b1;
         fwd_dataA = wData_q;
      end
      if (we_q && wReg_q == fwd_regB && fwd_regB != REG_ZERO) begin
         fwd_hitB  = 1'b1;
         fwd_dataB = wData_q;
      end
      for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
         if (CW'(k) < fifoCount) begin
            if (entries[ageIdx[k]].regIdx == fwd_regA && fwd_regA != REG_ZERO) begin
               fwd_hitA  = 1'b1;
               fwd_dataA = entries[ageIdx[k]].data;
            end
            if (entries[ageIdx[k]].regIdx == fwd_regB && fwd_regB != REG_ZERO) begin
               fwd_hitB  = 1'b1;
               fwd_dataB = entries[ageIdx[k]].data;
            end
         end
      end
   end

   assign ctrl_writeEnable = we_q;
   assign ctrl_writeReg    = wReg_q;
   assign data_writeReg    = wData_q;
   assign count            = fifoCount;

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Directed bench for regfile_writeback_queue with hand-computed expectations.
module tb_regfile_writeback_queue;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned AW    = 5;
   localparam int unsigned DW    = 32;
   localparam int unsigned CW    = $clog2(DEPTH + 1);

   logic          clock = 1'b0;
   logic          ctrl_reset_n;
   logic          in_valid;
   logic          in_ready;
   logic [AW-1:0] in_reg;
   logic [DW-1:0] in_data;
   logic          wb_hold;
   logic          flush;
   logic          ctrl_writeEnable;
   logic [AW-1:0] ctrl_writeReg;
   logic [DW-1:0] data_writeReg;
   logic [AW-1:0] fwd_regA, fwd_regB;
   logic          fwd_hitA, fwd_hitB;
   logic [DW-1:0] fwd_dataA, fwd_dataB;
   logic [CW-1:0] count;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   always #5 clock = ~clock;

   regfile_writeback_queue #(
      .DEPTH(DEPTH),
      .AW   (AW),
      .DW   (DW)
   ) dut (
      .clock           (clock),
      .ctrl_reset_n    (ctrl_reset_n),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_reg          (in_reg),
      .in_data         (in_data),
      .wb_hold         (wb_hold),
      .flush           (flush),
      .ctrl_writeEnable(ctrl_writeEnable),
      .ctrl_writeReg   (ctrl_writeReg),
      .data_writeReg   (data_writeReg),
      .fwd_regA        (fwd_regA),
      .fwd_regB        (fwd_regB),
      .fwd_hitA        (fwd_hitA),
      .fwd_hitB        (fwd_hitB),
      .fwd_dataA       (fwd_dataA),
      .fwd_dataB       (fwd_dataB),
      .count           (count)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic v, input logic [AW-1:0] r, input logic [DW-1:0] d);
      in_valid = v;
      in_reg   = r;
      in_data  = d;
   endtask

   initial begin
      ctrl_reset_n = 1'b0;
      drive(1'b0, '0, '0);
      wb_hold  = 1'b0;
      flush    = 1'b0;
      fwd_regA = 5'd5;
      fwd_regB = 5'd0;

      // Reset state
      #12;
      check_val("rst_we", ctrl_writeEnable, 0);
      check_val("rst_wreg", ctrl_writeReg, 0);
      check_val("rst_wdata", data_writeReg, 0);
      check_val("rst_count", count, 0);
      check_val("rst_ready", in_ready, 1);
      check_val("rst_hitA", fwd_hitA, 0);
      check_val("rst_dataA", fwd_dataA, 0);
      tick();
      ctrl_reset_n = 1'b1;
      tick();

      // 1. single write latency
      drive(1'b1, 5'd5, 32'hDEAD_BEEF);
      tick();
      drive(1'b0, '0, '0);
      check_val("t1_count1", count, 1);
      check_val("t1_we0", ctrl_writeEnable, 0);
      tick();
      #1;
      check_val("t1_we1", ctrl_writeEnable, 1);
      check_val("t1_wreg", ctrl_writeReg, 5);
      check_val("t1_wdata", data_writeReg, 32'hDEAD_BEEF);
      check_val("t1_count0", count, 0);
      check_val("t1_fwd_oreg_hit", fwd_hitA, 1);
      check_val("t1_fwd_oreg_data", fwd_dataA, 32'hDEAD_BEEF);
      tick();
      check_val("t1_we_drop", ctrl_writeEnable, 0);
      check_val("t1_wreg_hold", ctrl_writeReg, 5);
      check_val("t1_fwd_gone", fwd_hitA, 0);
      fwd_regA = 5'd0;

      // 2. fill under hold, reject when full, drain in order
      wb_hold = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         drive(1'b1, AW'(i), DW'(32'h100 + i));
         #1;
         check_val($sformatf("t2_ready%0d", i), in_ready, 1);
         tick();
      end
      check_val("t2_full_count", count, 4);
      check_val("t2_full_ready", in_ready, 0);
      drive(1'b1, 5'd9, 32'h999);
      tick();
      check_val("t2_no_push", count, 4);
      check_val("t2_held_we", ctrl_writeEnable, 0);
      drive(1'b0, '0, '0);
      wb_hold = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         tick();
         check_val($sformatf("t2_we%0d", i), ctrl_writeEnable, 1);
         check_val($sformatf("t2_reg%0d", i), ctrl_writeReg, i);
         check_val($sformatf("t2_data%0d", i), data_writeReg, 32'h100 + i);
      end
      tick();
      check_val("t2_we_end", ctrl_writeEnable, 0);
      check_val("t2_count_end", count, 0);

      // 3. r0 write consumed and dropped
      drive(1'b1, 5'd0, 32'h1234);
      #1;
      check_val("t3_ready", in_ready, 1);
      tick();
      drive(1'b0, '0, '0);
      fwd_regA = 5'd0;
      #1;
      check_val("t3_count", count, 0);
      check_val("t3_fwd_r0", fwd_hitA, 0);
      tick();
      check_val("t3_we_a", ctrl_writeEnable, 0);
      tick();
      check_val("t3_we_b", ctrl_writeEnable, 0);

      // 4. forwarding newest-first, then output register
      wb_hold = 1'b1;
      drive(1'b1, 5'd7, 32'd1);
      tick();
      drive(1'b1, 5'd7, 32'd2);
      tick();
      drive(1'b0, '0, '0);
      fwd_regA = 5'd7;
      fwd_regB = 5'd3;
      #1;
      check_val("t4_count", count, 2);
      check_val("t4_hitA", fwd_hitA, 1);
      check_val("t4_dataA", fwd_dataA, 2);
      check_val("t4_hitB", fwd_hitB, 0);
      check_val("t4_dataB", fwd_dataB, 0);
      fwd_regB = 5'd7;
      #1;
      check_val("t4_hitB7", fwd_hitB, 1);
      check_val("t4_dataB7", fwd_dataB, 2);
      fwd_regB = 5'd0;
      wb_hold = 1'b0;
      tick();
      check_val("t4_pop1_data", data_writeReg, 1);
      check_val("t4_pop1_fwd", fwd_dataA, 2);
      tick();
      check_val("t4_pop2_we", ctrl_writeEnable, 1);
      check_val("t4_pop2_hit", fwd_hitA, 1);
      check_val("t4_pop2_fwd", fwd_dataA, 2);
      tick();
      check_val("t4_after_hit", fwd_hitA, 0);
      check_val("t4_after_data", fwd_dataA, 0);
      fwd_regA = 5'd0;

      // 5. flush beats push and pop
      wb_hold = 1'b1;
      for (int i = 10; i <= 12; i++) begin
         drive(1'b1, AW'(i), DW'(i));
         tick();
      end
      check_val("t5_count3", count, 3);
      wb_hold = 1'b0;
      flush   = 1'b1;
      drive(1'b1, 5'd13, 32'h13);
      tick();
      flush = 1'b0;
      drive(1'b0, '0, '0);
      fwd_regA = 5'd13;
      fwd_regB = 5'd10;
      #1;
      check_val("t5_count0", count, 0);
      check_val("t5_we0", ctrl_writeEnable, 0);
      check_val("t5_push_lost", fwd_hitA, 0);
      check_val("t5_old_gone", fwd_hitB, 0);
      tick();
      check_val("t5_we_later", ctrl_writeEnable, 0);
      check_val("t5_count_later", count, 0);
      fwd_regA = 5'd0;
      fwd_regB = 5'd0;

      // 7. simultaneous push and pop keeps count
      drive(1'b1, 5'd2, 32'h22);
      tick();
      check_val("t7_count1", count, 1);
      drive(1'b1, 5'd3, 32'h33);
      tick();
      drive(1'b0, '0, '0);
      check_val("t7_count_same", count, 1);
      check_val("t7_reg2", ctrl_writeReg, 2);
      tick();
      check_val("t7_reg3", ctrl_writeReg, 3);
      check_val("t7_data3", data_writeReg, 32'h33);
      check_val("t7_count0", count, 0);
      tick();

      // 6. reset mid-drain drops everything
      wb_hold = 1'b1;
      drive(1'b1, 5'd20, 32'hAA);
      tick();
      drive(1'b1, 5'd21, 32'hBB);
      tick();
      drive(1'b0, '0, '0);
      check_val("t6_count2", count, 2);
      wb_hold = 1'b0;
      tick();
      check_val("t6_draining", ctrl_writeReg, 20);
      ctrl_reset_n = 1'b0;
      #1;
      check_val("t6_rst_we", ctrl_writeEnable, 0);
      check_val("t6_rst_wreg", ctrl_writeReg, 0);
      check_val("t6_rst_wdata", data_writeReg, 0);
      check_val("t6_rst_count", count, 0);
      check_val("t6_rst_ready", in_ready, 1);
      drive(1'b1, 5'd3, 32'h77);
      tick();
      check_val("t6_push_ignored", count, 0);
      drive(1'b0, '0, '0);
      ctrl_reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_val($sformatf("t6_no_stale%0d", i), ctrl_writeEnable, 0);
      end
      check_val("t6_count_end", count, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
